alu_packet_framer: RTL

Parametrised command framer that turns one ALU command (opcode plus up to `MAX_OPERANDS` operands) into the byte packet the ALU top expects on its UART receive path. It replaces per-byte host sequencing with a single command handshake. It streams header and little-endian operand bytes on an AXI-stream byte master that feeds the `uart` transmitter's `s_axis_*` inputs. It is used in the host-side bench and in loopback/self-test configurations.

---
 rtl/alu_packet_framer_pkg.sv | 22 ++
 rtl/alu_packet_framer_if.sv | 36 +++
 rtl/alu_packet_framer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_packet_framer_pkg.sv
// Shared types and constants for the ALU command packet framer.
// Opcodes, header size, FSM state encoding and the packet-length helper.
package alu_packet_pkg;

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD32 = 8'hA8;
    localparam logic [7:0] OP_MUL32 = 8'h88;
    localparam logic [7:0] OP_DIV32 = 8'h8A;

    localparam int HEADER_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_e;

    function automatic logic [15:0] pkt_len(input int unsigned count, input int unsigned op_bytes);
        return 16'(HEADER_BYTES + count * op_bytes);
    endfunction

endpackage

// File: rtl/alu_packet_framer_if.sv
// Command and byte-stream bundle for the packet framer; master = framer side.
// Both handshakes transfer on a rising edge where valid && ready; valid never waits on ready.
interface alu_packet_framer_if
    import alu_packet_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32,
    parameter int MAX_OPERANDS  = 4
);
    localparam int CNT_W = $clog2(MAX_OPERANDS + 1);

    logic [7:0]                            cmd_opcode_i;
    logic [CNT_W-1:0]                      cmd_count_i;
    logic [MAX_OPERANDS*OPERAND_WIDTH-1:0] cmd_operands_i;
    logic                                  cmd_valid_i;
    logic                                  cmd_ready_o;
    logic [7:0]                            m_axis_tdata_o;
    logic                                  m_axis_tvalid_o;
    logic                                  m_axis_tready_i;
    logic                                  m_axis_tlast_o;
    logic                                  busy_o;
    logic                                  cmd_error_o;
    state_e                                dbg_state;

    modport master (
        input  cmd_opcode_i, cmd_count_i, cmd_operands_i, cmd_valid_i, m_axis_tready_i,
        output cmd_ready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o,
        output busy_o, cmd_error_o, dbg_state
    );

    modport slave (
        output cmd_opcode_i, cmd_count_i, cmd_operands_i, cmd_valid_i, m_axis_tready_i,
        input  cmd_ready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o,
        input  busy_o, cmd_error_o, dbg_state
    );

endinterface

// File: rtl/alu_packet_framer.sv
// Turns one ALU command into the header + little-endian operand byte packet
// streamed to the UART transmitter over an AXI-stream byte master.
module alu_packet_framer
    import alu_packet_pkg::*;
#(
    parameter int OPERAND_WIDTH = 32,
    parameter int MAX_OPERANDS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_packet_framer_if.master bus
);
    localparam int CNT_W    = $clog2(MAX_OPERANDS + 1);
    localparam int OP_BYTES = OPERAND_WIDTH / 8;
    localparam int OPI_W    = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;
    localparam int BYI_W    = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
    localparam logic [BYI_W-1:0] BYTE_LAST = BYI_W'(OP_BYTES - 1);

    state_e                   state_q, state_d;
    logic                     init_q, init_d;
    logic                     err_q, err_d;
    logic [1:0]               hdr_idx_q, hdr_idx_d;
    logic [OPI_W-1:0]         op_idx_q, op_idx_d;
    logic [BYI_W-1:0]         byte_idx_q, byte_idx_d;
    logic [7:0]               opcode_q, opcode_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [15:0]              len_q, len_d;
    logic [OPERAND_WIDTH-1:0] operands_q [MAX_OPERANDS];
    logic [OPERAND_WIDTH-1:0] operands_d [MAX_OPERANDS];

    logic cmd_ready, accept, illegal, last_byte, last_op, tlast;
    logic [OPERAND_WIDTH-1:0] cur_op;
    logic [7:0] tdata;

    // init_q holds off cmd_ready until the first clock after reset release.
    assign cmd_ready = (state_q == IDLE) && init_q;
    assign accept    = bus.cmd_valid_i && cmd_ready;
    assign illegal   = (bus.cmd_count_i == '0) || (bus.cmd_count_i > CNT_W'(MAX_OPERANDS));
    assign last_byte = (byte_idx_q == BYTE_LAST);
    assign last_op   = (CNT_W'(op_idx_q) == count_q - CNT_W'(1));
    assign tlast     = (state_q == PAYLOAD) && last_byte && last_op;
    assign cur_op    = operands_q[op_idx_q];

    always_comb begin
        state_d    = state_q;
        init_d     = 1'b1;
        err_d      = 1'b0;
        hdr_idx_d  = hdr_idx_q;
        op_idx_d   = op_idx_q;
        byte_idx_d = byte_idx_q;
        opcode_d   = opcode_q;
        count_d    = count_q;
        len_d      = len_q;
        for (int k = 0; k < MAX_OPERANDS; k++) operands_d[k] = operands_q[k];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = HEADER;
                        hdr_idx_d  = 2'd0;
                        op_idx_d   = '0;
                        byte_idx_d = '0;
                        opcode_d   = bus.cmd_opcode_i;
                        count_d    = bus.cmd_count_i;
                        len_d      = pkt_len(32'(bus.cmd_count_i), OP_BYTES);
                        for (int k = 0; k < MAX_OPERANDS; k++)
                            operands_d[k] = bus.cmd_operands_i[k*OPERAND_WIDTH +: OPERAND_WIDTH];
                    end
                end
            end
            HEADER: begin
                if (bus.m_axis_tready_i) begin
                    if (hdr_idx_q == 2'd3) state_d = PAYLOAD;
                    else                   hdr_idx_d = hdr_idx_q + 2'd1;
                end
            end
            PAYLOAD: begin
                if (bus.m_axis_tready_i) begin
                    if (tlast) begin
                        state_d = IDLE;
                    end else if (last_byte) begin
                        byte_idx_d = '0;
                        op_idx_d   = op_idx_q + OPI_W'(1);
                    end else begin
                        byte_idx_d = byte_idx_q + BYI_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output byte is a pure function of registered state, so it holds while stalled.
    always_comb begin
        tdata = 8'h00;
        case (state_q)
            HEADER: begin
                case (hdr_idx_q)
                    2'd0:    tdata = opcode_q;
                    2'd1:    tdata = 8'h00;
                    2'd2:    tdata = len_q[7:0];
                    default: tdata = len_q[15:8];
                endcase
            end
            PAYLOAD: tdata = cur_op[{byte_idx_q, 3'b000} +: 8];
            default: tdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            init_q     <= 1'b0;
            err_q      <= 1'b0;
            hdr_idx_q  <= '0;
            op_idx_q   <= '0;
            byte_idx_q <= '0;
            opcode_q   <= '0;
            count_q    <= '0;
            len_q      <= '0;
            for (int k = 0; k < MAX_OPERANDS; k++) operands_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            err_q      <= err_d;
            hdr_idx_q  <= hdr_idx_d;
            op_idx_q   <= op_idx_d;
            byte_idx_q <= byte_idx_d;
            opcode_q   <= opcode_d;
            count_q    <= count_d;
            len_q      <= len_d;
            for (int k = 0; k < MAX_OPERANDS; k++) operands_q[k] <= operands_d[k];
        end
    end

    assign bus.cmd_ready_o     = cmd_ready;
    assign bus.m_axis_tdata_o  = tdata;
    assign bus.m_axis_tvalid_o = (state_q != IDLE);
    assign bus.m_axis_tlast_o  = tlast;
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.cmd_error_o     = err_q;
    assign bus.dbg_state       = state_q;

endmodule
